// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared waveform codes and increment FSM states for osc_multi_wave
// Contents:
//   WAVE_SAW/WAVE_TRI/WAVE_SQR/WAVE_PLS : wave_sel encodings
//   osc_state_t                         : increment FSM states (IDLE, DIV, LOAD)
package osc_pkg;

    localparam logic [1:0] WAVE_SAW = 2'b00;
    localparam logic [1:0] WAVE_TRI = 2'b01;
    localparam logic [1:0] WAVE_SQR = 2'b10;
    localparam logic [1:0] WAVE_PLS = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        LOAD
    } osc_state_t;

endpackage

// File: rtl/osc_multi_wave_if.sv
// rtl/osc_multi_wave_if.sv - frequency handshake and sample stream bundle for one oscillator voice
// Optional macro: OSC_HARD_SYNC_EN adds the sync signal.
// Signals:
//   freq/freq_valid/freq_ready : frequency request handshake (Hz, unsigned)
//   wave_sel/duty/amp          : waveform select, pulse threshold, amplitude
//   sample_en                  : advance phase and produce one sample
//   sample_out/sample_valid    : signed sample and its one-cycle strobe
//   sync                       : (OSC_HARD_SYNC_EN) restart phase on a sample_en strobe
// Modports: master drives requests, slave is the oscillator.
interface osc_multi_wave_if #(
    parameter int FREQ_W = 12,
    parameter int OUT_W  = 16
);
    import osc_pkg::*;

    logic [FREQ_W-1:0] freq;
    logic              freq_valid;
    logic              freq_ready;
    logic [1:0]        wave_sel;
    logic [7:0]        duty;
    logic [OUT_W-1:0]  amp;
    logic              sample_en;
    logic [OUT_W-1:0]  sample_out;
    logic              sample_valid;
`ifdef OSC_HARD_SYNC_EN
    logic              sync;
`endif

    modport master (
`ifdef OSC_HARD_SYNC_EN
        output sync,
`endif
        output freq, freq_valid, wave_sel, duty, amp, sample_en,
        input  freq_ready, sample_out, sample_valid
    );

    modport slave (
`ifdef OSC_HARD_SYNC_EN
        input  sync,
`endif
        input  freq, freq_valid, wave_sel, duty, amp, sample_en,
        output freq_ready, sample_out, sample_valid
    );

endinterface

// File: rtl/osc_inc_div.sv
// rtl/osc_inc_div.sv - iterative restoring divider turning a frequency in Hz into a phase increment
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : latch i_freq and begin a divide (ACC_W step cycles follow)
//   i_freq     : frequency in Hz
//   o_done     : high in the cycle whose clock edge produces the final quotient bit
//   o_quot     : floor(freq * 2^ACC_W / CLK_HZ), clamped to 2^(ACC_W-1)-1 for freq >= CLK_HZ/2
module osc_inc_div
    import osc_pkg::*;
#(
    parameter int ACC_W  = 24,
    parameter int FREQ_W = 12,
    parameter int CLK_HZ = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [FREQ_W-1:0] i_freq,
    output logic              o_done,
    output logic [ACC_W-1:0]  o_quot
);

    // Remainder always stays below CLK_HZ, so RR_W bits hold it; one extra bit
    // is needed only for the shifted trial value.
    localparam int              RR_W    = $clog2(CLK_HZ);
    localparam int              RD_W    = RR_W + 1;
    localparam int              CNT_W   = $clog2(ACC_W + 1);
    localparam logic [RD_W-1:0] DIVISOR = RD_W'(CLK_HZ);
    localparam logic [ACC_W-1:0] INC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

    logic [RR_W-1:0]  r_rem;
    logic [ACC_W-1:0] r_quot;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clamp;

    logic [RD_W-1:0]  w_shift;
    logic [RD_W-1:0]  w_sub;
    logic             w_ge;
    logic             w_unused_sub;

    // Dividend is freq followed by ACC_W zero bits: the remainder starts at freq
    // (valid because freq < CLK_HZ whenever the result is not clamped) and each
    // step shifts in a zero.
    assign w_shift      = {r_rem, 1'b0};
    assign w_sub        = w_shift - DIVISOR;
    assign w_ge         = (w_shift >= DIVISOR);
    assign w_unused_sub = w_sub[RD_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= '0;
            r_quot  <= '0;
            r_cnt   <= '0;
            r_clamp <= 1'b0;
        end else if (i_start) begin
            r_rem   <= RR_W'(i_freq);
            r_quot  <= '0;
            r_cnt   <= CNT_W'(ACC_W);
            r_clamp <= (32'(i_freq) >= 32'(CLK_HZ / 2));
        end else if (r_cnt != '0) begin
            r_rem   <= w_ge ? w_sub[RR_W-1:0] : w_shift[RR_W-1:0];
            r_quot  <= {r_quot[ACC_W-2:0], w_ge};
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == CNT_W'(1));
    assign o_quot = r_clamp ? INC_MAX : r_quot;

endmodule

// File: rtl/osc_multi_wave.sv
// rtl/osc_multi_wave.sv - phase-accumulator oscillator with saw/triangle/square/pulse output and amplitude scaling
// Optional macro: OSC_HARD_SYNC_EN (sync with sample_en restarts the phase at 0).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : osc_multi_wave_if.slave (frequency handshake, waveform controls, sample stream)
// Pipeline: sample_en at edge n updates the phase, edge n+1 registers the waveform,
// edge n+2 registers the scaled sample and sample_valid.
module osc_multi_wave
    import osc_pkg::*;
#(
    parameter int CLK_HZ       = 1000000,
    parameter int FREQ_W       = 12,
    parameter int ACC_W        = 24,
    parameter int OUT_W        = 16,
    parameter int DEFAULT_FREQ = 440
) (
    input  logic            clk,
    input  logic            rst_n,
    osc_multi_wave_if.slave bus
);

    localparam logic [ACC_W-1:0] INC_DEF   =
        ACC_W'((64'(DEFAULT_FREQ) << ACC_W) / 64'(CLK_HZ));
    localparam logic [OUT_W-1:0] W_MAX     = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] W_MIN     = {1'b1, {(OUT_W-1){1'b0}}};
    localparam int               PROD_W    = 2 * OUT_W + 2;

    osc_state_t       r_state;
    logic             r_freq_ready;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_phase;
    logic             r_v1;
    logic [OUT_W-1:0] r_w;
    logic [OUT_W-1:0] r_amp;
    logic             r_v2;
    logic [OUT_W-1:0] r_out;
    logic             r_valid;

    logic              w_hs;
    logic              w_div_done;
    logic [ACC_W-1:0]  w_quot;
    logic              w_sync;
    logic [OUT_W-1:0]  w_p;
    logic [OUT_W-2:0]  w_fold;
    logic [OUT_W-1:0]  w_wave;
    logic [OUT_W:0]    w_amp1;
    logic signed [PROD_W-1:0] w_wext;
    logic signed [PROD_W-1:0] w_aext;
    logic signed [PROD_W-1:0] w_prod;
    logic              w_unused_prod;

    assign w_hs = bus.freq_valid & r_freq_ready;

`ifdef OSC_HARD_SYNC_EN
    assign w_sync = bus.sync;
`else
    assign w_sync = 1'b0;
`endif

    osc_inc_div #(
        .ACC_W  (ACC_W),
        .FREQ_W (FREQ_W),
        .CLK_HZ (CLK_HZ)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_hs),
        .i_freq  (bus.freq),
        .o_done  (w_div_done),
        .o_quot  (w_quot)
    );

    // Handshake edge -> 24 DIV cycles -> LOAD writes inc; ready is low for ACC_W+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_freq_ready <= 1'b1;
            r_inc        <= INC_DEF;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_state      <= DIV;
                        r_freq_ready <= 1'b0;
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_inc        <= w_quot;
                    r_state      <= IDLE;
                    r_freq_ready <= 1'b1;
                end
                default: begin
                    r_state      <= IDLE;
                    r_freq_ready <= 1'b1;
                end
            endcase
        end
    end

    // Stage 1: a strobe coinciding with LOAD still sees the old r_inc here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_v1    <= 1'b0;
        end else begin
            r_v1 <= bus.sample_en;
            if (bus.sample_en) begin
                r_phase <= w_sync ? '0 : r_phase + r_inc;
            end
        end
    end

    assign w_p    = r_phase[ACC_W-1 -: OUT_W];
    assign w_fold = w_p[OUT_W-1] ? ~w_p[OUT_W-2:0] : w_p[OUT_W-2:0];

    always_comb begin
        w_wave = {~w_p[OUT_W-1], w_p[OUT_W-2:0]};
        case (bus.wave_sel)
            WAVE_SAW: w_wave = {~w_p[OUT_W-1], w_p[OUT_W-2:0]};
            WAVE_TRI: w_wave = {~w_fold[OUT_W-2], w_fold[OUT_W-3:0], 1'b0};
            WAVE_SQR: w_wave = w_p[OUT_W-1] ? W_MIN : W_MAX;
            WAVE_PLS: w_wave = (w_p[OUT_W-1 -: 8] < bus.duty) ? W_MAX : W_MIN;
            default:  w_wave = {~w_p[OUT_W-1], w_p[OUT_W-2:0]};
        endcase
    end

    // Stage 2: waveform and amplitude are captured together so one sample uses one setting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w   <= '0;
            r_amp <= '0;
            r_v2  <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_w   <= w_wave;
                r_amp <= bus.amp;
            end
        end
    end

    // amp+1 keeps all-ones amplitude an exact passthrough (multiply by 2^OUT_W).
    assign w_amp1 = {1'b0, r_amp} + {{OUT_W{1'b0}}, 1'b1};
    assign w_wext = {{(OUT_W+2){r_w[OUT_W-1]}}, r_w};
    assign w_aext = {{(OUT_W+1){1'b0}}, w_amp1};
    assign w_prod = w_wext * w_aext;
    assign w_unused_prod = ^{w_prod[PROD_W-1:2*OUT_W], w_prod[OUT_W-1:0]};

    // Stage 3: taking bits [2*OUT_W-1:OUT_W] is the arithmetic shift by OUT_W, truncated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_v2;
            if (r_v2) begin
                r_out <= w_prod[2*OUT_W-1:OUT_W];
            end
        end
    end

    assign bus.freq_ready   = r_freq_ready;
    assign bus.sample_out   = r_out;
    assign bus.sample_valid = r_valid;

endmodule

// File: tb/tb_osc_multi_wave.sv
// tb/tb_osc_multi_wave.sv - self-checking bench for osc_multi_wave (default and CLK_HZ=4000 instances)
module tb_osc_multi_wave;

    localparam longint CLK_A = 1000000;
    localparam longint CLK_B = 4000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    longint      m_phase [2];
    longint      m_inc   [2];
    logic [1:0]  cur_ws  [2];
    logic [7:0]  cur_duty[2];
    logic [15:0] cur_amp [2];
    logic [15:0] lit_tab [4];

    osc_multi_wave_if #(.FREQ_W(12), .OUT_W(16)) if0 ();
    osc_multi_wave_if #(.FREQ_W(12), .OUT_W(16)) if4 ();

    osc_multi_wave dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    osc_multi_wave #(.CLK_HZ(4000)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    function automatic longint model_inc(input longint f, input longint c);
        if (f >= c / 2) return (longint'(1) << 23) - 1;
        return (f << 24) / c;
    endfunction

    function automatic logic [15:0] model_sample(input longint phase, input logic [1:0] ws,
                                                 input logic [7:0] duty, input logic [15:0] amp);
        longint p;
        longint w;
        longint prod;
        p = phase >> 8;
        case (ws)
            2'd0:    w = p - 32768;
            2'd1:    w = (p < 32768) ? 2 * p - 32768 : 2 * (65535 - p) - 32768;
            2'd2:    w = (p >= 32768) ? -32768 : 32767;
            default: w = ((p >> 8) < longint'(duty)) ? 32767 : -32768;
        endcase
        prod = w * (longint'(amp) + 1);
        return 16'(prod >>> 16);
    endfunction

    function automatic logic rd_valid(input int sel);
        return (sel == 0) ? if0.sample_valid : if4.sample_valid;
    endfunction

    function automatic logic [15:0] rd_out(input int sel);
        return (sel == 0) ? if0.sample_out : if4.sample_out;
    endfunction

    function automatic logic rd_ready(input int sel);
        return (sel == 0) ? if0.freq_ready : if4.freq_ready;
    endfunction

    task automatic drv_en(input int sel, input logic en);
        if (sel == 0) if0.sample_en = en;
        else          if4.sample_en = en;
    endtask

    task automatic drv_freq(input int sel, input int f, input logic v);
        if (sel == 0) begin if0.freq = 12'(f); if0.freq_valid = v; end
        else          begin if4.freq = 12'(f); if4.freq_valid = v; end
    endtask

    task automatic set_wave(input int sel, input logic [1:0] ws, input logic [7:0] duty,
                            input logic [15:0] amp);
        cur_ws[sel] = ws; cur_duty[sel] = duty; cur_amp[sel] = amp;
        if (sel == 0) begin if0.wave_sel = ws; if0.duty = duty; if0.amp = amp; end
        else          begin if4.wave_sel = ws; if4.duty = duty; if4.amp = amp; end
    endtask

    task automatic model_reset;
        for (int s = 0; s < 2; s++) m_phase[s] = 0;
        m_inc[0] = (longint'(440) << 24) / CLK_A;
        m_inc[1] = (longint'(440) << 24) / CLK_B;
    endtask

    // Handshake one frequency; ready must drop for exactly 25 cycles.
    task automatic set_freq(input int sel, input int f, input string name);
        int cnt;
        @(negedge clk);
        checks++;
        if (rd_ready(sel) !== 1'b1) begin
            errors++; $display("FAIL %s ready_idle: got %b want 1", name, rd_ready(sel));
        end
        drv_freq(sel, f, 1'b1);
        @(negedge clk);
        drv_freq(sel, f, 1'b0);
        cnt = 0;
        while (rd_ready(sel) === 1'b0 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 25) begin
            errors++; $display("FAIL %s busy_cycles: got %0d want 25", name, cnt);
        end
        m_inc[sel] = model_inc(f, (sel == 0) ? CLK_A : CLK_B);
    endtask

    // Issue n strobes separated by gap idle cycles; check valid every cycle and each sample.
    task automatic run_strobes(input int sel, input int n, input int gap, input int sync_at,
                               input string name, input bit use_lit);
        bit          sched[$];
        logic [15:0] expq[$];
        logic [15:0] e;
        logic        exp_v;
        bit          do_sync;
        int          k;
        int          total;
        for (int i = 0; i < n; i++) begin
            sched.push_back(1'b1);
            for (int g = 0; g < gap; g++) sched.push_back(1'b0);
        end
        total = sched.size() + 4;
        k = 0;
        for (int j = 0; j < total; j++) begin
            @(negedge clk);
            exp_v = (j >= 3 && j - 3 < sched.size()) ? sched[j-3] : 1'b0;
            checks++;
            if (rd_valid(sel) !== exp_v) begin
                errors++;
                $display("FAIL %s valid[%0d]: got %b want %b", name, j, rd_valid(sel), exp_v);
            end
            if (exp_v && expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (rd_out(sel) !== e) begin
                    errors++;
                    $display("FAIL %s sample[%0d]: got %h want %h", name, j - 3, rd_out(sel), e);
                end
            end
            if (j < sched.size() && sched[j]) begin
`ifdef OSC_HARD_SYNC_EN
                do_sync = (k == sync_at);
                if (sel == 0) if0.sync = do_sync; else if4.sync = do_sync;
`else
                do_sync = 1'b0;
`endif
                m_phase[sel] = do_sync ? 0 : (m_phase[sel] + m_inc[sel]) % (longint'(1) << 24);
                expq.push_back(use_lit ? lit_tab[k % 4]
                                       : model_sample(m_phase[sel], cur_ws[sel], cur_duty[sel], cur_amp[sel]));
                drv_en(sel, 1'b1);
                k++;
            end else begin
                drv_en(sel, 1'b0);
`ifdef OSC_HARD_SYNC_EN
                if (sel == 0) if0.sync = 1'b0; else if4.sync = 1'b0;
`endif
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (if0.freq_ready !== 1'b1 || if4.freq_ready !== 1'b1) begin
            errors++; $display("FAIL %s freq_ready: got %b/%b want 1/1", name, if0.freq_ready, if4.freq_ready);
        end
        checks++;
        if (if0.sample_valid !== 1'b0 || if4.sample_valid !== 1'b0) begin
            errors++; $display("FAIL %s sample_valid: got %b/%b want 0/0", name, if0.sample_valid, if4.sample_valid);
        end
        checks++;
        if (if0.sample_out !== 16'h0 || if4.sample_out !== 16'h0) begin
            errors++; $display("FAIL %s sample_out: got %h/%h want 0/0", name, if0.sample_out, if4.sample_out);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        check_reset_values("reset_initial");
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset_mid_div;
        set_wave(0, 2'd0, 8'h00, 16'hFFFF);
        run_strobes(0, 3, 1, -1, "pre_reset_saw", 1'b0);
        @(negedge clk);
        drv_freq(0, 1000, 1'b1);
        @(negedge clk);
        drv_freq(0, 1000, 1'b0);
        repeat (8) @(negedge clk);
        checks++;
        if (if0.freq_ready !== 1'b0) begin
            errors++; $display("FAIL mid_div_busy: got %b want 0", if0.freq_ready);
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_async");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_default_inc;
        set_wave(0, 2'd0, 8'h00, 16'hFFFF);
        run_strobes(0, 300, 0, -1, "default_inc_b2b", 1'b0);
    endtask

    task automatic test_freq_1000;
        set_freq(0, 1000, "freq1000");
        run_strobes(0, 40, 1, -1, "freq1000_saw", 1'b0);
    endtask

    task automatic test_waves_4k;
        set_freq(1, 1000, "freq4k");
        set_wave(1, 2'd0, 8'h00, 16'hFFFF);
        lit_tab = '{16'hC000, 16'h0000, 16'h4000, 16'h8000};
        run_strobes(1, 4, 2, -1, "saw_full", 1'b1);
        set_wave(1, 2'd1, 8'h00, 16'hFFFF);
        lit_tab = '{16'h0000, 16'h7FFE, 16'hFFFE, 16'h8000};
        run_strobes(1, 4, 1, -1, "tri_full", 1'b1);
        set_wave(1, 2'd0, 8'h00, 16'h7FFF);
        lit_tab = '{16'hE000, 16'h0000, 16'h2000, 16'hC000};
        run_strobes(1, 4, 0, -1, "saw_half", 1'b1);
        set_wave(1, 2'd3, 8'h80, 16'hFFFF);
        lit_tab = '{16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF};
        run_strobes(1, 4, 1, -1, "pulse_80", 1'b1);
    endtask

    task automatic test_boundaries;
        set_freq(1, 0, "freq_zero");
        set_wave(1, 2'd0, 8'h00, 16'hFFFF);
        lit_tab = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        run_strobes(1, 4, 0, -1, "freq_zero_const", 1'b1);
        set_freq(1, 2000, "clamp_half");
        lit_tab = '{16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h7FFF};
        run_strobes(1, 4, 0, -1, "clamp_saw", 1'b1);
        set_freq(1, 3000, "clamp_above");
        set_wave(1, 2'd2, 8'h00, 16'h1234);
        run_strobes(1, 6, 1, -1, "clamp_square", 1'b0);
        set_wave(1, 2'd3, 8'h00, 16'hFFFF);
        run_strobes(1, 4, 0, -1, "pulse_duty0", 1'b0);
    endtask

    task automatic test_random;
        int sel;
        int f;
        for (int it = 0; it < 10; it++) begin
            sel = it % 2;
            f = (sel == 1) ? int'($urandom_range(2300, 0)) : int'($urandom_range(4095, 0));
            set_freq(sel, f, "rand_freq");
            set_wave(sel, 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)), 16'($urandom));
            run_strobes(sel, int'($urandom_range(12, 1)), int'($urandom_range(2, 0)), -1, "rand", 1'b0);
        end
    endtask

`ifdef OSC_HARD_SYNC_EN
    task automatic test_sync;
        set_freq(1, 1000, "sync_freq");
        set_wave(1, 2'd0, 8'h00, 16'hFFFF);
        run_strobes(1, 6, 1, 2, "hard_sync", 1'b0);
    endtask
`endif

    initial begin
        if0.freq = '0; if0.freq_valid = 1'b0; if0.sample_en = 1'b0;
        if4.freq = '0; if4.freq_valid = 1'b0; if4.sample_en = 1'b0;
`ifdef OSC_HARD_SYNC_EN
        if0.sync = 1'b0; if4.sync = 1'b0;
`endif
        set_wave(0, 2'd0, 8'h00, 16'hFFFF);
        set_wave(1, 2'd0, 8'h00, 16'hFFFF);
        test_reset();
        test_reset_mid_div();
        test_default_inc();
        test_freq_1000();
        test_waves_4k();
        test_boundaries();
        test_random();
`ifdef OSC_HARD_SYNC_EN
        test_sync();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/osc_multi_wave.md
Name: osc_multi_wave

Overview:
Parametrised phase-accumulator oscillator and successor to the fixed 440 Hz saw/triangle generator. A frequency in Hz is converted to a phase increment by an iterative divider, and changes are phase-continuous. Each sample_en strobe produces one amplitude-scaled signed sample, with the waveform chosen from saw, triangle, square or variable-duty pulse. The block sits between the key/frequency front end and the voice mixer, one instance per voice.

Parameters:
CLK_HZ, 1000000, clk frequency in Hz; divisor for the increment calculation
FREQ_W, 12, width of the freq input
ACC_W, 24, phase accumulator width; must be >= OUT_W and >= 9
OUT_W, 16, sample width, two's complement
DEFAULT_FREQ, 440, frequency in effect after reset

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
freq  in  FREQ_W  requested frequency in Hz (unsigned)
freq_valid  in  1  freq offered this cycle
freq_ready  out  1  divider idle; freq accepted when freq_valid and freq_ready are both high
wave_sel  in  2  waveform: 00 saw, 01 triangle, 10 square, 11 pulse
duty  in  8  pulse threshold; high fraction = duty/256
amp  in  OUT_W  unsigned amplitude; output = (w*(amp+1)) >>> OUT_W
sample_en  in  1  advance phase and produce one sample
sample_out  out  OUT_W  signed sample
sample_valid  out  1  one-cycle pulse, sample_out updated

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values:
  - phase = 0; inc = INC_DEF = floor(DEFAULT_FREQ*2^ACC_W/CLK_HZ), a localparam.
  - sample_out = 0, sample_valid = 0, freq_ready = 1, FSM = IDLE.
- Increment FSM:
  - IDLE: freq_ready = 1. A handshake latches freq and goes to DIV.
  - DIV: restoring divide of freq<<ACC_W by CLK_HZ, one quotient bit per cycle, ACC_W cycles, freq_ready = 0. Then go to LOAD.
  - LOAD: inc <= quotient, then back to IDLE.
  - Handshake to new inc active: ACC_W+1 cycles. freq_valid while busy is not accepted; the producer holds.
- Boundary cases:
  - freq = 0: inc = 0 and the phase freezes.
  - freq >= CLK_HZ/2: inc clamps to 2^(ACC_W-1)-1.
  - Reset mid-DIV aborts the divide; inc returns to INC_DEF.
  - The phase is never cleared by a frequency change.
- Phase: on each sample_en, phase <= phase + inc, modulo 2^ACC_W with silent wrap. p = phase[ACC_W-1 -: OUT_W], taken after the update.
- Waveforms (w is signed, OUT_W bits; MAX/MIN are the signed extremes):
  - saw: p with its MSB inverted.
  - tri: f = p[MSB] ? ~p[OUT_W-2:0] : p[OUT_W-2:0]; w = {f,1'b0} with MSB inverted.
  - square: p[MSB] ? MIN : MAX.
  - pulse: p[MSB -: 8] < duty ? MAX : MIN. duty = 0 gives constant MIN.
- Scaling: product is OUT_W+1 x OUT_W+1 signed, arithmetic shift right by OUT_W, truncated to OUT_W. amp = all-ones is exact passthrough.
- Pipeline and latency:
  - Stage 1 updates phase. Stage 2 registers w, sampling wave_sel, duty and amp. Stage 3 registers sample_out and sample_valid.
  - sample_en at edge n gives sample_valid at edge n+2, one pulse per strobe.
  - Back-to-back sample_en every cycle is supported.
  - An inc load in the same cycle as sample_en: the phase uses the old inc for that strobe.

Optional Feature:
OSC_HARD_SYNC_EN
- Defined: adds input sync (1 bit). sync high together with sample_en sets phase to 0 instead of phase+inc. The sample then reflects p = 0 (saw = MIN). sync without sample_en is ignored.
- Undefined: no sync port, and the phase only free-runs.

Decomposition:
- Package osc_pkg: the wave_sel codes (WAVE_SAW, WAVE_TRI, WAVE_SQR, WAVE_PLS) and the FSM state typedef (IDLE, DIV, LOAD).
- Sub-module osc_inc_div: iterative divider with start/done, parameters ACC_W, FREQ_W, CLK_HZ, and the clamp.
- The top level holds the FSM handshake, the accumulator, the waveform mapping and the scaler.

Test Plan:
- Reset mid-operation: assert rst_n low during DIV -> all outputs at reset values, freq_ready = 1; inc = 7381 at default parameters (440*2^24/1e6 = 7381.97, floored).
- freq = 1000 handshake -> freq_ready low for exactly 25 cycles; inc = 16777.
- Saw with CLK_HZ = 4000, FREQ_W = 12, freq = 1000, amp = 0xFFFF -> inc = 0x400000. Four strobes give 0xC000, 0x0000, 0x4000, 0x8000, each valid 2 cycles after its strobe.
- Same setup, triangle -> 0x0000, 0x7FFE, 0xFFFE, 0x8000.
- Same setup, amp = 0x7FFF -> saw 0xE000, 0x0000, 0x2000, 0xC000. Pulse with duty = 0x80 -> 0x7FFF, 0x8000, 0x8000, 0x7FFF.
- freq = 0 -> constant output. Edge case freq >= CLK_HZ/2 (e.g. 2000 at CLK_HZ = 4000) -> inc = 0x7FFFFF. With OSC_HARD_SYNC_EN defined, sync on the third strobe -> saw 0x8000 and the phase restarts from 0.
